// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : MEM-stage request/response channel between CPU and dmem.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Word-addressed data memory with wait states, one outstanding
//               transaction and misaligned/out-of-range error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  dmem_responder_if.slave bus
);

  localparam int          c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  c_LAT   = 4'(LATENCY);
  localparam logic [29:0] c_DEPTH = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;

  logic         r_write;
  logic [31:0]  r_addr;
  logic [31:0]  r_wdata;
  logic         r_req_ready;
  logic         r_rsp_valid;
  logic [31:0]  r_rsp_rdata;
  logic         r_rsp_err;
  logic [31:0]  r_mem [DEPTH_WORDS];

  logic               w_accept;
  logic               w_access;
  logic               w_acc_write;
  logic [31:0]        w_acc_addr;
  logic [31:0]        w_acc_wdata;
  logic               w_acc_err;
  logic [c_IDX_W-1:0] w_acc_idx;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // With zero wait states the access uses the live request, not the latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    w_acc_write = r_write;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          w_acc_write = bus.req_write_i;
          w_acc_addr  = bus.req_addr_i;
          w_acc_wdata = bus.req_wdata_i;
          if (c_LAT == 4'd0) begin
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = c_LAT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= c_DEPTH);
  assign w_acc_idx = w_acc_addr[c_IDX_W+1:2];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_write     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write_i;
        r_addr  <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
      end
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      if (w_access) begin
        r_rsp_err   <= w_acc_err;
        r_rsp_rdata <= (w_acc_err || w_acc_write) ? 32'd0 : r_mem[w_acc_idx];
        if (!w_acc_err && w_acc_write) begin
          r_mem[w_acc_idx] <= w_acc_wdata;
        end
      end else if ((r_state == ST_RESP) && bus.rsp_ready_i) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= 32'd0;
      end
    end
  end

  assign bus.req_ready_o = r_req_ready;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder that serves load/store requests from the pipelined CPU's MEM stage over a valid/ready request channel and a valid/ready response channel. It models a memory with a configurable number of wait states, holds exactly one outstanding transaction, and flags misaligned or out-of-range accesses. It replaces the zero-latency data memory when the CPU is built with MEM-stage stall support.

## Interface
- `DEPTH_WORDS`, default 128: number of 32-bit words stored; valid word index is 0..DEPTH_WORDS-1.
- `LATENCY`, default 2: wait-state cycles between request acceptance and response; legal range 0..15.

- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  responder can accept a request this cycle.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  CPU takes the response this cycle.
- `rsp_rdata_o`  out  32  load data; 0 for stores and errored accesses.
- `rsp_err_o`  out  1  access was misaligned or out of range.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset state is IDLE.
- While `rst_i`=0:
  - state is IDLE;
  - `req_ready_o`=1, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0;
  - the wait counter is 0;
  - every memory word is cleared to 0.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`&`req_ready_o`, latch write, addr and wdata.
  - If LATENCY>0, go to WAIT with counter=LATENCY. If LATENCY=0, go directly to RESP and perform the access on the same edge.
- WAIT:
  - `req_ready_o`=0; the counter decrements each cycle.
  - On the edge where counter==1, go to RESP and perform the access.
- Access, performed on the edge that enters RESP:
  - Error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. Then no memory change, `rsp_err_o`=1, `rsp_rdata_o`=0.
  - Load: `rsp_rdata_o`=mem[addr[31:2]], `rsp_err_o`=0.
  - Store: mem[addr[31:2]]=wdata, `rsp_rdata_o`=0, `rsp_err_o`=0.
- RESP:
  - `rsp_valid_o`=1; `rsp_rdata_o` and `rsp_err_o` are held stable.
  - On `rsp_ready_i`=1, go to IDLE. Outputs clear to 0 on that edge.
- Request inputs are ignored outside IDLE. The CPU must hold them stable until accepted.
- Only one transaction is outstanding. There is no accept in the same cycle as a response handshake.

## Timing
- Request accepted at the end of cycle T.
- `rsp_valid_o` first high in cycle T+1+LATENCY.
- With `rsp_ready_i` held at 1: response handshake at the end of cycle T+1+LATENCY; `req_ready_o` high again in cycle T+2+LATENCY.
- Peak throughput is one transaction per LATENCY+2 cycles.
- A store's new value is visible to a load accepted on or after the cycle in which the store's `rsp_valid_o` is high.
- Backpressure: RESP lasts as long as `rsp_ready_i` is low. Nothing else advances.
- Async reset mid-transaction (any state) aborts it immediately:
  - a pending store in WAIT is not committed;
  - `rsp_valid_o` drops without a handshake;
  - memory is cleared.
- All outputs are registered and come straight from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** assert `rst_i`=0 mid-WAIT of a store to word 3, then release and load word 3 → `req_ready_o`=1 in the cycle after release, `rsp_valid_o`=0, load returns 0x00000000 with `rsp_err_o`=0.
- **Latency, LATENCY=2:** store 0xDEADBEEF to addr 0x10 accepted at cycle 5 → `rsp_valid_o` high in cycle 8, rdata 0, err 0. Then load addr 0x10 → rdata 0xDEADBEEF, valid exactly 3 cycles after its accept.
- **Zero latency:** with LATENCY=0, load addr 0x0 accepted at cycle T → `rsp_valid_o` in cycle T+1; `req_ready_o` back in cycle T+2 with `rsp_ready_i`=1.
- **Backpressure:** hold `rsp_ready_i`=0 for 5 cycles in RESP while `req_valid_i`=1 with a new request → `rsp_valid_o` and rdata stable all 5 cycles, `req_ready_o`=0, the second request is not accepted until the cycle after the handshake.
- **Errors:**
  - load addr 0x6 → err 1, rdata 0;
  - store 0x55 to addr 4*DEPTH_WORDS → err 1;
  - a following load of word 0 is unchanged.
- **Back-to-back:** stores of values 1..8 to words 0..7, then loads of the same words with random `rsp_ready_i` stalls → each load returns its stored value and no transaction is ever lost or duplicated.
